// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and helpers for the pipelined multiplier.
//   OUT_SEL_*  result slice selectors (low half, high half, full product)
//   owidth()   result port width for a given operand width and slice
package mult_pkg;

  localparam int OUT_SEL_LO   = 0;
  localparam int OUT_SEL_HI   = 1;
  localparam int OUT_SEL_FULL = 2;

  function automatic int owidth(input int width, input int out_sel);
    return (out_sel == OUT_SEL_FULL) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one pipeline slot (valid bit + data register) with enable.
//   clk, reset   clock and synchronous active-high reset
//   en           load vld_d/dat_d this cycle, otherwise hold
//   vld_d/dat_d  next valid bit and data
//   vld_q/dat_q  registered valid bit and data
// Only the valid bit is reset; the data register is left free-running so it
// carries no reset fan-out.
module mult_pipe_stage #(
  parameter int DW         = 32,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          vld_d,
  input  logic [DW-1:0] dat_d,
  output logic          vld_q,
  output logic [DW-1:0] dat_q
);

  always_ff @(posedge clk) begin
    if (reset && CLR_ON_RST) vld_q <= 1'b0;
    else if (en)             vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (en) dat_q <= dat_d;
  end

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined multiplier joining two valid/ready operand streams
// into one valid/ready result stream.
//   clk, reset                 clock, synchronous active-high reset
//   i_a_valid/o_a_ready/i_a    operand A stream
//   i_b_valid/o_b_ready/i_b    operand B stream
//   o_result_valid/i_result_ready/o_result  result stream (OWIDTH bits)
// The full 2*WIDTH product is formed in stage 0 and carried unchanged; the
// output slice is taken combinationally from the last stage. Each stage
// advances when it is empty or the stage after it advances, so bubbles are
// squeezed out even while the output is stalled.
module mult_pipe
  import mult_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int LATENCY = 3,
  parameter  int SIGNED  = 0,
  parameter  int OUT_SEL = 1,
  localparam int OWIDTH  = owidth(WIDTH, OUT_SEL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [WIDTH-1:0]  i_a,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic [WIDTH-1:0]  i_b,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [OWIDTH-1:0] o_result
);

  localparam int PW = 2 * WIDTH;

  if (LATENCY < 1 || OUT_SEL < 0 || OUT_SEL > 2 || WIDTH < 2) begin : g_bad_cfg
    $fatal(1, "mult_pipe: illegal WIDTH/LATENCY/OUT_SEL");
  end

  logic [LATENCY-1:0]         en;
  logic [LATENCY-1:0]         vld_d, vld_q;
  logic [LATENCY-1:0][PW-1:0] dat_d, dat_q;
  logic [PW-1:0]              a_ext, b_ext, prod;
  logic                       take;

  // Stage k may load if any stage from k to the end is empty, or the output
  // drains. Written as a scan over valid bits rather than a chain through en
  // so there is no self-referencing vector.
  always_comb begin
    en = '0;
    for (int k = 0; k < LATENCY; k++) begin
      en[k] = i_result_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!vld_q[j]) en[k] = 1'b1;
      end
    end
  end

  // Join: each side's ready depends on the other side's valid so neither
  // operand is ever consumed alone. Reset blocks all transfers.
  always_comb begin
    o_a_ready = !reset && en[0] && i_b_valid;
    o_b_ready = !reset && en[0] && i_a_valid;
    take      = !reset && en[0] && i_a_valid && i_b_valid;
  end

  // Extend to the product width so the truncated multiply is the exact
  // two's-complement (or unsigned) product.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
      b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    end else begin
      a_ext = {{WIDTH{1'b0}}, i_a};
      b_ext = {{WIDTH{1'b0}}, i_b};
    end
    prod = a_ext * b_ext;
  end

  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = take;
    dat_d[0] = prod;
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
    end
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    mult_pipe_stage #(
      .DW         (PW),
      .CLR_ON_RST (1'b1)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (en[k]),
      .vld_d (vld_d[k]),
      .dat_d (dat_d[k]),
      .vld_q (vld_q[k]),
      .dat_q (dat_q[k])
    );
  end

  assign o_result_valid = vld_q[LATENCY-1];

  if (OUT_SEL == OUT_SEL_FULL) begin : g_full
    assign o_result = dat_q[LATENCY-1];
  end else if (OUT_SEL == OUT_SEL_HI) begin : g_hi
    logic unused_lo;
    assign o_result  = dat_q[LATENCY-1][PW-1:WIDTH];
    assign unused_lo = ^dat_q[LATENCY-1][WIDTH-1:0];
  end else begin : g_lo
    logic unused_hi;
    assign o_result  = dat_q[LATENCY-1][WIDTH-1:0];
    assign unused_hi = ^dat_q[LATENCY-1][PW-1:WIDTH];
  end

endmodule

// File: tb/tb_mult_pipe.sv
module tb_mult_pipe;

  typedef struct packed {
    logic [15:0] u;   // unsigned full product
    logic [7:0]  hi;  // signed product, high byte
    logic [7:0]  lo;  // signed product, low byte
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, result_ready = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic        a_rdy, b_rdy, u_vld;
  logic        hi_a_rdy, hi_b_rdy, hi_vld;
  logic        lo_a_rdy, lo_b_rdy, lo_vld;
  logic [15:0] r_u;
  logic [7:0]  r_hi, r_lo;

  int checks = 0, errors = 0;
  int n_push = 0, n_pop = 0, cyc = 0, last_pop_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_pipe #(.WIDTH(8), .LATENCY(3), .SIGNED(0), .OUT_SEL(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_a_valid(a_valid), .o_a_ready(a_rdy), .i_a(a),
    .i_b_valid(b_valid), .o_b_ready(b_rdy), .i_b(b),
    .o_result_valid(u_vld), .i_result_ready(result_ready), .o_result(r_u));

  mult_pipe #(.WIDTH(8), .LATENCY(3), .SIGNED(1), .OUT_SEL(1)) u_shi (
    .clk(clk), .reset(reset),
    .i_a_valid(a_valid), .o_a_ready(hi_a_rdy), .i_a(a),
    .i_b_valid(b_valid), .o_b_ready(hi_b_rdy), .i_b(b),
    .o_result_valid(hi_vld), .i_result_ready(result_ready), .o_result(r_hi));

  mult_pipe #(.WIDTH(8), .LATENCY(3), .SIGNED(1), .OUT_SEL(0)) u_slo (
    .clk(clk), .reset(reset),
    .i_a_valid(a_valid), .o_a_ready(lo_a_rdy), .i_a(a),
    .i_b_valid(b_valid), .o_b_ready(lo_b_rdy), .i_b(b),
    .o_result_valid(lo_vld), .i_result_ready(result_ready), .o_result(r_lo));

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    logic [15:0]        pu;
    logic signed [15:0] ps;
    pu = x * y;
    ps = $signed(x) * $signed(y);
    model.u  = pu;
    model.hi = ps[15:8];
    model.lo = ps[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard pop on every output transfer; all three instances share the
  // handshake, so their valids/readies must agree with the main one.
  always @(negedge clk) begin
    if (!reset) begin
      if (hi_vld !== u_vld || lo_vld !== u_vld || hi_a_rdy !== a_rdy ||
          lo_a_rdy !== a_rdy || hi_b_rdy !== b_rdy || lo_b_rdy !== b_rdy) begin
        checks++; errors++;
        $display("FAIL lockstep: vld %b/%b/%b rdy %b/%b/%b", u_vld, hi_vld, lo_vld, a_rdy, hi_a_rdy, lo_a_rdy);
      end
      if (u_vld && result_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h/%h/%h expected none", r_u, r_hi, r_lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (r_u !== e.u || r_hi !== e.hi || r_lo !== e.lo) begin
            errors++;
            $display("FAIL result: got %h/%h/%h expected %h/%h/%h", r_u, r_hi, r_lo, e.u, e.hi, e.lo);
          end
        end
        n_pop++;
        last_pop_cyc = cyc;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input exp_t e);
    int n = 0;
    a = va; b = vb; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    while (!(a_rdy && b_rdy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no transfer expected transfer for %h*%h", va, vb);
    end else begin
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    int base, c0, held;
    vecs[0] = '{8'd200, 8'd100, '{16'h4E20, 8'hEA, 8'h20}};
    vecs[1] = '{8'h80,  8'h80,  '{16'h4000, 8'h40, 8'h00}};
    vecs[2] = '{8'hFF,  8'h01,  '{16'h00FF, 8'hFF, 8'hFF}};
    vecs[3] = '{8'h7F,  8'hFE,  '{16'h7E02, 8'hFF, 8'h02}};
    vecs[4] = '{8'hFF,  8'hFF,  '{16'hFE01, 8'h00, 8'h01}};
    vecs[5] = '{8'h00,  8'h55,  '{16'h0000, 8'h00, 8'h00}};
    vecs[6] = '{8'h7F,  8'h7F,  '{16'h3F01, 8'h3F, 8'h01}};
    vecs[7] = '{8'h80,  8'h01,  '{16'h0080, 8'hFF, 8'h80}};

    // Reset: readies forced low even with both valids up
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_rdy, 0);
    chk("rst_b_ready", b_rdy, 0);
    chk("rst_valid", u_vld, 0);
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Latency: present on cycle 0, valid exactly on cycle 3
    a = 8'd200; b = 8'd100; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready", a_rdy, 1);
    sb.push_back(vecs[0].e); n_push++;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("lat_c1", u_vld, 0);
    @(posedge clk); #1;
    chk("lat_c2", u_vld, 0);
    @(posedge clk); #1;
    chk("lat_c3_valid", u_vld, 1);
    chk("lat_c3_data", r_u, 16'h4E20);
    drain();

    // Table vectors back-to-back: one result per cycle, in order
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].e);
    drain();
    chk("throughput", last_pop_cyc - c0, 8 + 2);

    // Join: A alone is never taken
    base = n_pop;
    a = 8'd9; b = 8'd7; a_valid = 1'b1; b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("join_a_ready", a_rdy, 0);
      chk("join_no_result", u_vld, 0);
      @(posedge clk); #1;
    end
    send(8'd9, 8'd7, model(8'd9, 8'd7));
    drain();
    chk("join_one_result", n_pop - base, 1);

    // Backpressure: 10 pairs, output stalled from cycle 2
    base = n_push;
    c0 = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] x, y;
          x = 8'(i * 17 + 3);
          y = 8'(250 - i * 13);
          send(x, y, model(x, y));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 result_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_accepted", n_push - base, 3);
        chk("bp_a_ready", a_rdy, 0);
        chk("bp_b_ready", b_rdy, 0);
        chk("bp_valid", u_vld, 1);
        held = r_u;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stable", r_u, held);
        chk("bp_valid_held", u_vld, 1);
        result_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", n_pop - c0, 10);

    // Bubble collapse: pair, idle, pair, stalled -> third pair still fits
    result_ready = 1'b0;
    base = n_push;
    c0 = n_pop;
    send(8'd3, 8'd5, model(8'd3, 8'd5));
    @(posedge clk); #1;
    send(8'd11, 8'd13, model(8'd11, 8'd13));
    send(8'd17, 8'd19, model(8'd17, 8'd19));
    chk("bubble_accepted", n_push - base, 3);
    a = 8'd23; b = 8'd29; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bubble_full", a_rdy, 0);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    send(8'd23, 8'd29, model(8'd23, 8'd29));
    drain();
    chk("bubble_delivered", n_pop - c0, 4);

    // Reset with three results in flight
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(40 + i), 8'(60 + i), model(8'(40 + i), 8'(60 + i)));
    reset = 1'b1;
    sb.delete();
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    chk("midrst_a_ready", a_rdy, 0);
    chk("midrst_b_ready", b_rdy, 0);
    @(posedge clk); #1;
    chk("midrst_valid", {u_vld, hi_vld, lo_vld}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; result_ready = 1'b1;
    c0 = n_pop;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_stale", n_pop - c0, 0);
    chk("midrst_idle_valid", u_vld, 0);
    send(8'd100, 8'd3, model(8'd100, 8'd3));
    drain();

    // Random stream with random output stalls
    c0 = n_pop;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [7:0] x, y;
          x = 8'($urandom_range(0, 255));
          y = 8'($urandom_range(0, 255));
          send(x, y, model(x, y));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk); #1;
          result_ready = ($urandom_range(0, 3) != 0);
        end
        result_ready = 1'b1;
      end
    join
    result_ready = 1'b1;
    drain();
    chk("rand_delivered", n_pop - c0, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
